dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
module dmem_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_memop,
  input  logic [31:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [1:0]      resp_err
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

  state_t          state, state_nx;
  logic [31:0]     rel;
  logic [31:0]     idx;
  logic [2:0]      off;
  logic            accept;
  logic            illegal, out_range, misaligned;
  logic [1:0]      err;
  logic [NB-1:0]   bmask, wmask;
  logic [XLEN-1:0] wrep;
  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_fmt;
  logic [2:0]      ld_op;
  logic [2:0]      ld_off;

  assign rel    = req_addr - BASE_ADDR;
  assign idx    = rel >> OFF_W;
  assign off    = 3'(rel[OFF_W-1:0]);
  assign accept = req_valid & req_ready;

  always_comb begin
    illegal = (req_memop == 3'b111) || (req_we && req_memop[2]);
    if (XLEN == 32 && (req_memop == 3'b011 || req_memop == 3'b110))
      illegal = 1'b1;
    out_range  = (req_addr < BASE_ADDR) || (idx >= 32'(DEPTH));
    misaligned = 1'b0;
    case (req_memop[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      2'b11:   misaligned = |off;
      default: misaligned = 1'b0;
    endcase
    if (illegal)         err = 2'b11;
    else if (out_range)  err = 2'b10;
    else if (misaligned) err = 2'b01;
    else                 err = 2'b00;
  end

  always_comb begin
    case (req_memop[1:0])
      2'b00: begin
        wrep  = {NB{req_wdata[7:0]}};
        bmask = NB'(1);
      end
      2'b01: begin
        wrep  = {(NB/2){req_wdata[15:0]}};
        bmask = NB'(3);
      end
      2'b10: begin
        wrep  = {(NB/4){req_wdata[31:0]}};
        bmask = NB'(15);
      end
      default: begin
        wrep  = req_wdata;
        bmask = '1;
      end
    endcase
    wmask = '0;
    if (accept && req_we && err == 2'b00)
      wmask = bmask << off;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++)
      if (wmask[i])
        mem[idx[AW-1:0]][8*i +: 8] <= wrep[8*i +: 8];
    if (accept && !req_we && err == 2'b00)
      rd_word <= mem[idx[AW-1:0]];
  end

  always_comb begin
    lane = rd_word >> {ld_off, 3'b000};
    case (ld_op)
      3'b000:  ld_fmt = XLEN'($signed(lane[7:0]));
      3'b001:  ld_fmt = XLEN'($signed(lane[15:0]));
      3'b010:  ld_fmt = XLEN'($signed(lane[31:0]));
      3'b011:  ld_fmt = lane;
      3'b100:  ld_fmt = XLEN'(lane[7:0]);
      3'b101:  ld_fmt = XLEN'(lane[15:0]);
      3'b110:  ld_fmt = XLEN'(lane[31:0]);
      default: ld_fmt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (accept)
          state_nx = (req_we || err != 2'b00) ? RESP : LOAD;
      end
      LOAD: state_nx = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= '0;
      ld_op      <= '0;
      ld_off     <= '0;
    end else if (accept) begin
      resp_rdata <= '0;
      resp_err   <= err;
      ld_op      <= req_memop;
      ld_off     <= off;
    end else if (state == LOAD) begin
      resp_rdata <= ld_fmt;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

   localparam logic [31:0] B32 = 32'h0000_1000;
   localparam int unsigned D32 = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b0;

   logic        a_req_valid = 0, a_req_ready, a_req_we = 0, a_resp_valid, a_resp_ready = 1;
   logic [2:0]  a_req_memop = 0;
   logic [31:0] a_req_addr = 0, a_req_wdata = 0, a_resp_rdata;
   logic [1:0]  a_resp_err;

   logic        b_req_valid = 0, b_req_ready, b_req_we = 0, b_resp_valid, b_resp_ready = 1;
   logic [2:0]  b_req_memop = 0;
   logic [31:0] b_req_addr = 0;
   logic [63:0] b_req_wdata = 0, b_resp_rdata;
   logic [1:0]  b_resp_err;

   int total = 0;
   int bad   = 0;
   byte unsigned ref_mem [256];

   dmem_ctrl #(.XLEN(32), .DEPTH(D32), .BASE_ADDR(B32)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_memop(a_req_memop), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
      .resp_rdata(a_resp_rdata), .resp_err(a_resp_err));

   dmem_ctrl #(.XLEN(64), .DEPTH(64), .BASE_ADDR(32'h0)) u_dut64 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_memop(b_req_memop), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata), .resp_err(b_resp_err));

   // One full transaction on the 32-bit instance; lat counts edges from
   // the accept edge (inclusive) until resp_valid is seen.
   task automatic txn32(input logic we, input logic [2:0] op, input logic [31:0] ad,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic [1:0] er, output int lat);
      int k = 0;
      rd = '0; er = '0; lat = 0;
      @(negedge clk);
      while (a_req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      if (a_req_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL accept32 req_ready=%b want 1", a_req_ready);
         return;
      end
      a_req_valid = 1; a_req_we = we; a_req_memop = op; a_req_addr = ad; a_req_wdata = wd;
      @(posedge clk); #1 a_req_valid = 0;
      lat = 1;
      @(negedge clk);
      while (a_resp_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
      rd = a_resp_rdata; er = a_resp_err;
      if (a_resp_valid === 1'b1) @(posedge clk);
   endtask

   task automatic txn64(input logic we, input logic [2:0] op, input logic [31:0] ad,
                        input logic [63:0] wd, output logic [63:0] rd,
                        output logic [1:0] er, output int lat);
      int k = 0;
      rd = '0; er = '0; lat = 0;
      @(negedge clk);
      while (b_req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      if (b_req_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL accept64 req_ready=%b want 1", b_req_ready);
         return;
      end
      b_req_valid = 1; b_req_we = we; b_req_memop = op; b_req_addr = ad; b_req_wdata = wd;
      @(posedge clk); #1 b_req_valid = 0;
      lat = 1;
      @(negedge clk);
      while (b_resp_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
      rd = b_resp_rdata; er = b_resp_err;
      if (b_resp_valid === 1'b1) @(posedge clk);
   endtask

   // Reference: byte-addressed memory image, rules applied arithmetically.
   function automatic void model32(input logic we, input logic [2:0] op, input logic [31:0] ad,
                                   input logic [31:0] wd, output logic [31:0] rd,
                                   output logic [1:0] er);
      int unsigned sz = 1 << op[1:0];
      longint unsigned rel, v;
      rd = '0; er = 2'd0;
      if (op == 3'd7 || op == 3'd3 || op == 3'd6 || (we && op >= 3'd4)) er = 2'd3;
      else if (ad < B32 || ((ad - B32) / 4) >= D32) er = 2'd2;
      else if (((ad - B32) % sz) != 0) er = 2'd1;
      if (er != 2'd0) return;
      rel = longint'(ad - B32);
      if (we) begin
         for (int unsigned k = 0; k < sz; k++) ref_mem[rel + k] = 8'(wd >> (8 * k));
      end else begin
         v = 0;
         for (int unsigned k = 0; k < sz; k++) v |= longint'(ref_mem[rel + k]) << (8 * k);
         if (!op[2] && v[8 * sz - 1]) v |= ~((64'd1 << (8 * sz)) - 1);
         rd = v[31:0];
      end
   endfunction

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (a_req_ready !== 0 || a_resp_valid !== 0 || a_resp_rdata !== 0 || a_resp_err !== 0) begin
         bad++;
         $display("FAIL reset32 rdy=%b vld=%b rdata=%h err=%b want 0/0/0/0",
                  a_req_ready, a_resp_valid, a_resp_rdata, a_resp_err);
      end
      total++;
      if (b_req_ready !== 0 || b_resp_valid !== 0 || b_resp_rdata !== 0 || b_resp_err !== 0) begin
         bad++;
         $display("FAIL reset64 rdy=%b vld=%b rdata=%h err=%b want 0/0/0/0",
                  b_req_ready, b_resp_valid, b_resp_rdata, b_resp_err);
      end
      rst_n = 1;
      @(negedge clk);
      total++;
      if (a_req_ready !== 1 || b_req_ready !== 1) begin
         bad++;
         $display("FAIL reset_release rdy32=%b rdy64=%b want 1/1", a_req_ready, b_req_ready);
      end
   endtask

   task automatic test_load_store32();
      logic [31:0] rd; logic [1:0] er; int lat;
      txn32(1, 3'b010, B32 + 32'h10, 32'hDEADBEEF, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 0 || lat !== 1) begin bad++;
         $display("FAIL sw_10 err=%0d rdata=%h lat=%0d want 0/0/1", er, rd, lat); end
      txn32(0, 3'b000, B32 + 32'h13, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 32'hFFFFFFDE || lat !== 2) begin bad++;
         $display("FAIL lb_13 err=%0d rdata=%h lat=%0d want 0/ffffffde/2", er, rd, lat); end
      txn32(0, 3'b100, B32 + 32'h13, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 32'h000000DE) begin bad++;
         $display("FAIL lbu_13 err=%0d rdata=%h want 0/000000de", er, rd); end
      txn32(1, 3'b010, B32 + 32'h20, 32'hAAAAAAAA, rd, er, lat);
      txn32(1, 3'b001, B32 + 32'h22, 32'h00001234, rd, er, lat);
      total++;
      if (er !== 0 || lat !== 1) begin bad++;
         $display("FAIL sh_22 err=%0d lat=%0d want 0/1", er, lat); end
      txn32(0, 3'b010, B32 + 32'h20, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 32'h1234AAAA) begin bad++;
         $display("FAIL lw_20 err=%0d rdata=%h want 0/1234aaaa", er, rd); end
      txn32(0, 3'b001, B32 + 32'h22, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 32'h00001234) begin bad++;
         $display("FAIL lh_22 err=%0d rdata=%h want 0/00001234", er, rd); end
      txn32(1, 3'b010, B32 + 32'hFC, 32'hCAFEF00D, rd, er, lat);
      txn32(0, 3'b010, B32 + 32'hFC, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 32'hCAFEF00D) begin bad++;
         $display("FAIL lw_last err=%0d rdata=%h want 0/cafef00d", er, rd); end
   endtask

   task automatic test_errors32();
      logic [31:0] rd; logic [1:0] er; int lat;
      txn32(0, 3'b010, B32 + 32'h2, 0, rd, er, lat);
      total++;
      if (er !== 2'b01 || rd !== 0 || lat !== 1) begin bad++;
         $display("FAIL lw_misaligned err=%0d rdata=%h lat=%0d want 1/0/1", er, rd, lat); end
      txn32(1, 3'b010, B32 + 4 * D32, 32'h12345678, rd, er, lat);
      total++;
      if (er !== 2'b10 || rd !== 0 || lat !== 1) begin bad++;
         $display("FAIL sw_range err=%0d rdata=%h lat=%0d want 2/0/1", er, rd, lat); end
      txn32(0, 3'b010, B32 - 4, 0, rd, er, lat);
      total++;
      if (er !== 2'b10 || lat !== 1) begin bad++;
         $display("FAIL lw_below err=%0d lat=%0d want 2/1", er, lat); end
      txn32(0, 3'b111, B32, 0, rd, er, lat);
      total++;
      if (er !== 2'b11 || rd !== 0 || lat !== 1) begin bad++;
         $display("FAIL memop7 err=%0d rdata=%h lat=%0d want 3/0/1", er, rd, lat); end
      txn32(0, 3'b011, B32, 0, rd, er, lat);
      total++;
      if (er !== 2'b11 || lat !== 1) begin bad++;
         $display("FAIL memop3_x32 err=%0d lat=%0d want 3/1", er, lat); end
      txn32(1, 3'b100, B32 + 32'h10, 32'h0, rd, er, lat);
      total++;
      if (er !== 2'b11) begin bad++;
         $display("FAIL store_bu err=%0d want 3", er); end
      txn32(1, 3'b010, B32 + 32'h12, 32'h0, rd, er, lat);
      total++;
      if (er !== 2'b01) begin bad++;
         $display("FAIL sw_misaligned err=%0d want 1", er); end
      txn32(0, 3'b010, B32 + 32'h10, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 32'hDEADBEEF) begin bad++;
         $display("FAIL no_write_on_err err=%0d rdata=%h want 0/deadbeef", er, rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic [1:0] er; int lat;
      txn32(1, 3'b010, B32 + 32'h30, 32'h55667788, rd, er, lat);
      @(negedge clk);
      a_resp_ready = 0;
      a_req_valid = 1; a_req_we = 0; a_req_memop = 3'b010; a_req_addr = B32 + 32'h30;
      @(posedge clk); #1 a_req_valid = 0;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (a_resp_valid !== 1 || a_resp_rdata !== 32'h55667788 || a_resp_err !== 0 || a_req_ready !== 0) begin
            bad++;
            $display("FAIL hold_%0d vld=%b rdata=%h err=%0d rdy=%b want 1/55667788/0/0",
                     i, a_resp_valid, a_resp_rdata, a_resp_err, a_req_ready);
         end
      end
      a_resp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (a_req_ready !== 1 || a_resp_valid !== 0) begin bad++;
         $display("FAIL release rdy=%b vld=%b want 1/0", a_req_ready, a_resp_valid); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic [1:0] er; int lat;
      @(negedge clk);
      a_req_valid = 1; a_req_we = 0; a_req_memop = 3'b010; a_req_addr = B32 + 32'h10;
      @(posedge clk); #1 a_req_valid = 0;
      @(negedge clk);
      rst_n = 0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (a_resp_valid !== 0) begin bad++;
         $display("FAIL rst_in_load vld=%b want 0", a_resp_valid); end
      rst_n = 1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (a_resp_valid !== 0 || a_req_ready !== 1) begin bad++;
         $display("FAIL rst_to_idle vld=%b rdy=%b want 0/1", a_resp_valid, a_req_ready); end
      // Store presented at an edge where reset is asserted.
      a_req_valid = 1; a_req_we = 1; a_req_memop = 3'b010; a_req_addr = B32 + 32'h10;
      a_req_wdata = 32'h11111111; rst_n = 0;
      @(posedge clk); #1 a_req_valid = 0;
      @(negedge clk);
      rst_n = 1;
      txn32(0, 3'b010, B32 + 32'h10, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 32'hDEADBEEF) begin bad++;
         $display("FAIL rst_at_store err=%0d rdata=%h want 0/deadbeef", er, rd); end
   endtask

   task automatic test_xlen64();
      logic [63:0] rd; logic [1:0] er; int lat;
      txn64(1, 3'b011, 32'h8, 64'h0123456789ABCDEF, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 0 || lat !== 1) begin bad++;
         $display("FAIL sd_8 err=%0d rdata=%h lat=%0d want 0/0/1", er, rd, lat); end
      txn64(0, 3'b110, 32'hC, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 64'h0000000001234567 || lat !== 2) begin bad++;
         $display("FAIL lwu_c err=%0d rdata=%h lat=%0d want 0/0000000001234567/2", er, rd, lat); end
      txn64(0, 3'b010, 32'h8, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 64'hFFFFFFFF89ABCDEF) begin bad++;
         $display("FAIL lw_8 err=%0d rdata=%h want 0/ffffffff89abcdef", er, rd); end
      txn64(1, 3'b000, 32'h9, 64'h00000000000000FF, rd, er, lat);
      txn64(0, 3'b011, 32'h8, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 64'h0123456789ABFFEF) begin bad++;
         $display("FAIL ld_after_sb err=%0d rdata=%h want 0/0123456789abffef", er, rd); end
      txn64(0, 3'b011, 32'hC, 0, rd, er, lat);
      total++;
      if (er !== 2'b01 || rd !== 0 || lat !== 1) begin bad++;
         $display("FAIL ld_misaligned err=%0d rdata=%h lat=%0d want 1/0/1", er, rd, lat); end
      txn64(0, 3'b001, 32'hE, 0, rd, er, lat);
      total++;
      if (er !== 0 || rd !== 64'h0000000000000123) begin bad++;
         $display("FAIL lh_e err=%0d rdata=%h want 0/0000000000000123", er, rd); end
      txn64(0, 3'b010, 32'd512, 0, rd, er, lat);
      total++;
      if (er !== 2'b10) begin bad++;
         $display("FAIL lw_range64 err=%0d want 2", er); end
   endtask

   task automatic test_random32();
      logic [31:0] rd, xrd, ad, wd; logic [1:0] er, xer; int lat, xlat;
      logic we; logic [2:0] op; int unsigned r;
      for (int i = 0; i < 64; i++) begin
         wd = $urandom;
         model32(1, 3'b010, B32 + 4 * i, wd, xrd, xer);
         txn32(1, 3'b010, B32 + 4 * i, wd, rd, er, lat);
         total++;
         if (er !== xer) begin bad++;
            $display("FAIL prefill_%0d err=%0d want %0d", i, er, xer); end
      end
      for (int n = 0; n < 300; n++) begin
         we = 1'($urandom % 2);
         op = 3'($urandom % 8);
         r  = $urandom % 16;
         if (r == 0)      ad = B32 + 4 * D32 + ($urandom % 64);
         else if (r == 1) ad = B32 - 1 - ($urandom % 16);
         else             ad = B32 + ($urandom % 256);
         wd = $urandom;
         model32(we, op, ad, wd, xrd, xer);
         xlat = (xer != 0 || we) ? 1 : 2;
         txn32(we, op, ad, wd, rd, er, lat);
         total++;
         if (er !== xer || rd !== xrd || lat !== xlat) begin bad++;
            $display("FAIL rand_%0d we=%b op=%0d addr=%h err=%0d rdata=%h lat=%0d want %0d/%h/%0d",
                     n, we, op, ad, er, rd, lat, xer, xrd, xlat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_store32();
      test_errors32();
      test_backpressure();
      test_reset_mid();
      test_xlen64();
      test_random32();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
